platform_tracker: RTL

Holds the on-screen platform set for the doodle game and answers one question per game step: did the descending doodle land on a platform, or fall off the bottom? It sits beside `doodle_sm`, consuming the doodle's position and descend status. It feeds back a `Land` pulse, which restarts the jump, or a `Fall` pulse, which ends the game. It also scrolls platforms downward and respawns them at the top from an LFSR, and exposes a read port for the renderer.

---
 rtl/doodle_pkg.sv | 28 ++
 rtl/lfsr8.sv | 29 ++
 rtl/platform_tracker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// Shared encodings and constants for the doodle game platform logic.
package doodle_pkg;

  // One-hot state encodings for the platform tracker FSM.
  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_CHECK  = 4'b0010;
  localparam logic [3:0] S_RESULT = 4'b0100;
  localparam logic [3:0] S_SCROLL = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE   = S_IDLE,
    ST_CHECK  = S_CHECK,
    ST_RESULT = S_RESULT,
    ST_SCROLL = S_SCROLL
  } state_e;

  // Screen geometry.
  localparam int         SCREEN_W  = 256;
  localparam logic [7:0] Y_TOP_DEF = 8'd239;

  // Taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3 of a left-shifting register).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR that advances only when enabled.
module lfsr8
  import doodle_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  output logic [7:0] Q
);

  logic [7:0] lfsr_q, lfsr_d;

  // Advance by one step on enable, otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (En) lfsr_d = lfsr_next(lfsr_q);
  end

  // State register with synchronous active-low reset to the seed.
  always_ff @(posedge Clk) begin
    if (!Reset) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign Q = lfsr_q;

endmodule

// File: rtl/platform_tracker.sv
// Platform set for the doodle game: per-step collision scan (land / fall),
// one-pixel scrolling with LFSR-driven respawn at the top, and a renderer read port.
//
// state  | meaning
// IDLE   | waiting for Check or Scroll (or a pending scroll)
// CHECK  | comparing latched doodle position against one slot per cycle
// RESULT | one cycle presenting Land / Fall from the accumulated hit flag
// SCROLL | moving one slot down per cycle, respawning slots that reach y == 0
module platform_tracker
  import doodle_pkg::*;
#(
  parameter int         N_PLAT = 4,
  parameter int         PW     = 16,
  parameter logic [7:0] Y_TOP  = Y_TOP_DEF,
  parameter logic [7:0] SEED   = 8'hA5,
  localparam int        IW     = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Check,
  input  logic          Scroll,
  input  logic [7:0]    Dx,
  input  logic [7:0]    Dy,
  input  logic          Descending,
  input  logic [IW-1:0] Rd_idx,
  output logic [7:0]    Rd_x,
  output logic [7:0]    Rd_y,
  output logic          Busy,
  output logic          Land,
  output logic          Fall,
  output logic [7:0]    Spawned
);

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1 - PW);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    dx_q, dx_d;
  logic [7:0]    dy_q, dy_d;
  logic          desc_q, desc_d;
  logic          hit_q, hit_d;
  logic          pend_q, pend_d;
  logic [7:0]    spawned_q, spawned_d;

  logic [7:0]    plat_x_q [N_PLAT];
  logic [7:0]    plat_y_q [N_PLAT];

  logic [7:0]    cur_x, cur_y;
  logic [8:0]    x_lo, x_hi, dx9;
  logic          slot_hit;
  logic          last_slot;
  logic          respawn;
  logic [7:0]    lfsr_val;
  logic [7:0]    new_x, new_y;

  // Spawner randomness, stepped once per respawn.
  lfsr8 #(.SEED(SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (respawn),
    .Q     (lfsr_val)
  );

  // Slot under the scan/scroll pointer and its hit/respawn evaluation (9-bit so x+PW-1 cannot wrap).
  always_comb begin
    cur_x     = plat_x_q[idx_q];
    cur_y     = plat_y_q[idx_q];
    x_lo      = {1'b0, cur_x};
    x_hi      = x_lo + 9'(PW - 1);
    dx9       = {1'b0, dx_q};
    slot_hit  = (dy_q == cur_y) && (x_lo <= dx9) && (dx9 <= x_hi);
    last_slot = (idx_q == IW'(N_PLAT - 1));
    respawn   = (state_q == ST_SCROLL) && (cur_y == 8'd0);
    new_y     = respawn ? Y_TOP : cur_y - 8'd1;
    new_x     = cur_x;
    if (respawn) new_x = (lfsr_val <= X_MAX) ? lfsr_val : lfsr_val - 8'(PW);
  end

  // Next-state logic: request arbitration, scan accumulation, scroll sequencing.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    desc_d    = desc_q;
    hit_d     = hit_q;
    pend_d    = pend_q;
    spawned_d = spawned_q;
    case (state_q)
      ST_IDLE: begin
        if (Check) begin
          dx_d    = Dx;
          dy_d    = Dy;
          desc_d  = Descending;
          hit_d   = 1'b0;
          idx_d   = '0;
          pend_d  = pend_q | Scroll;
          state_d = ST_CHECK;
        end else if (Scroll || pend_q) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_SCROLL;
        end
      end
      ST_CHECK: begin
        pend_d = pend_q | Scroll;
        hit_d  = hit_q | slot_hit;
        idx_d  = idx_q + IW'(1);
        if (last_slot) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        pend_d  = pend_q | Scroll;
        state_d = ST_IDLE;
      end
      ST_SCROLL: begin
        pend_d = pend_q | Scroll;
        idx_d  = idx_q + IW'(1);
        if (respawn && (spawned_q != 8'hFF)) spawned_d = spawned_q + 8'd1;
        if (last_slot) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dx_q      <= 8'd0;
      dy_q      <= 8'd0;
      desc_q    <= 1'b0;
      hit_q     <= 1'b0;
      pend_q    <= 1'b0;
      spawned_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      desc_q    <= desc_d;
      hit_q     <= hit_d;
      pend_q    <= pend_d;
      spawned_q <= spawned_d;
    end
  end

  // Platform storage: staggered initial layout, one slot rewritten per SCROLL cycle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < N_PLAT; i++) begin
        plat_x_q[i] <= 8'(40 * i + 8);
        plat_y_q[i] <= 8'(60 * i);
      end
    end else if (state_q == ST_SCROLL) begin
      plat_x_q[idx_q] <= new_x;
      plat_y_q[idx_q] <= new_y;
    end
  end

  assign Rd_x    = plat_x_q[Rd_idx];
  assign Rd_y    = plat_y_q[Rd_idx];
  assign Busy    = (state_q != ST_IDLE);
  assign Land    = (state_q == ST_RESULT) &  hit_q & desc_q;
  assign Fall    = (state_q == ST_RESULT) & ~hit_q & desc_q & (dy_q == 8'd0);
  assign Spawned = spawned_q;

endmodule
